// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button debounce logic.
package key_pkg;

  // Per-key debounce FSM states
  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    REL_CHK
  } key_state_t;

  localparam int unsigned CLK_HZ = 50_000_000;

  // 20 ms debounce, 500 ms first repeat, 100 ms repeat period
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;
  localparam int unsigned REPEAT_DELAY_DEF    = CLK_HZ / 2;
  localparam int unsigned REPEAT_PERIOD_DEF   = CLK_HZ / 10;

  // Bits needed for a counter whose largest held value is max_count - 1
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, debounce FSM, stable counter and auto-repeat timer.
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RepeatDelay    = REPEAT_DELAY_DEF,
  parameter int unsigned RepeatPeriod   = REPEAT_PERIOD_DEF,
  parameter bit          RepeatEn       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned DbW    = cnt_width(DebounceCycles);
  localparam int unsigned RptMax = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
  localparam int unsigned RptW   = cnt_width(RptMax);

  localparam logic [DbW-1:0]  DbLast     = DbW'(DebounceCycles - 1);
  localparam logic [RptW-1:0] RptDlyLast = RptW'(RepeatDelay - 1);
  localparam logic [RptW-1:0] RptPerLast = RptW'(RepeatPeriod - 1);

  logic            sync1_q, sync2_q;
  key_state_t      state_q, state_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_armed_q, rpt_armed_d;  // first repeat already emitted
  logic [RptW-1:0] rpt_last;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            repeat_q, repeat_d;

  // Two-flop synchroniser; resets to the released level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM next state, stable counter and press/release pulses
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (!sync2_q) begin
          db_cnt_d = '0;
          state_d  = PRESS_CHK;
        end
      end
      PRESS_CHK: begin
        if (sync2_q) begin
          state_d = RELEASED;
        end else if (db_cnt_q >= DbLast) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
      PRESSED: begin
        if (sync2_q) begin
          db_cnt_d = '0;
          state_d  = REL_CHK;
        end
      end
      REL_CHK: begin
        if (!sync2_q) begin
          state_d = PRESSED;
        end else if (db_cnt_q >= DbLast) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign rpt_last = rpt_armed_q ? RptPerLast : RptDlyLast;

  // Auto-repeat timer; entering RELEASED clears it so release always beats a repeat tick
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    repeat_d    = 1'b0;
    if (!RepeatEn || press_d || (state_d == RELEASED)) begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end else if ((state_q == PRESSED) || (state_q == REL_CHK)) begin
      if (rpt_cnt_q >= rpt_last) begin
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b1;
        repeat_d    = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RptW'(1);
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RELEASED;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces N active-low push buttons into level, press, release and repeat pulses.
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int unsigned        N_KEYS          = 4,
  parameter int unsigned        DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned        REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned        REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter logic [N_KEYS-1:0]  REPEAT_EN       = {N_KEYS{1'b0}}
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .RepeatDelay   (REPEAT_DELAY),
      .RepeatPeriod  (REPEAT_PERIOD),
      .RepeatEn      (REPEAT_EN[i])
    ) u_cell (
      .clk_i    (CLOCK_50),
      .rst_ni   (rst_n),
      .key_n_i  (key_n[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .repeat_o (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench: stimulus queues expected pulses, a monitor matches DUT pulses.
module tb_key_debounce_pulse;

  localparam int unsigned NK = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  always #5 clk = ~clk;

  key_debounce_pulse #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5),
    .REPEAT_EN      (4'b0001)
  ) dut (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  typedef struct {
    int kind;  // 0 press, 1 release, 2 repeat
    int key;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;

  function automatic string kname(input int k);
    return (k == 0) ? "press" : (k == 1) ? "release" : "repeat";
  endfunction

  function automatic void push(input int kind, input int key, input int c);
    ev_t e;
    e.kind = kind;
    e.key  = key;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: count edges, match every output pulse against the queue head
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < int'(NK); k++) begin
        for (int t = 0; t < 3; t++) begin
          logic p;
          p = (t == 0) ? key_press[k] : (t == 1) ? key_release[k] : key_repeat[k];
          if (p) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_pulse: got %s key %0d at cycle %0d, expected none",
                       kname(t), k, cyc);
            end else begin
              ev_t e;
              e = exp_q.pop_front();
              if (e.kind != t || e.key != k || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL pulse_match: got %s key %0d at cycle %0d, expected %s key %0d at cycle %0d",
                         kname(t), k, cyc, kname(e.kind), e.key, e.cyc);
              end
            end
          end
        end
      end
      // Anything still queued for this cycle or earlier never appeared
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL missed_pulse: got nothing by cycle %0d, expected %s key %0d at cycle %0d",
                 cyc, kname(e.kind), e.key, e.cyc);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  // Stimulus; t0 is the first edge that samples the new key_n value
  initial begin
    int t0;
    int t1;

    // Reset values
    wait_cycles(3);
    chk("rst_level",   key_level,   4'b0000);
    chk("rst_press",   key_press,   4'b0000);
    chk("rst_release", key_release, 4'b0000);
    chk("rst_repeat",  key_repeat,  4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(5);

    // Clean press on key 1, held 30 cycles
    t0 = cyc + 1;
    push(0, 1, t0 + 10);
    push(1, 1, t0 + 40);
    key_n[1] = 1'b0;
    wait_cycles(20);
    chk("clean_level_hi", key_level, 4'b0010);
    wait_cycles(10);
    key_n[1] = 1'b1;
    wait_cycles(5);
    chk("clean_level_hold", key_level, 4'b0010);
    wait_cycles(15);
    chk("clean_level_lo", key_level, 4'b0000);

    // Bounce on key 2: never stable long enough
    for (int i = 0; i < 4; i++) begin
      key_n[2] = 1'b0;
      wait_cycles(3);
      key_n[2] = 1'b1;
      wait_cycles(2);
    end
    chk("bounce_level_a", key_level, 4'b0000);
    wait_cycles(15);
    chk("bounce_level_b", key_level, 4'b0000);

    // Auto-repeat on key 0; release acceptance lands on a repeat tick and wins
    t0 = cyc + 1;
    push(0, 0, t0 + 10);
    for (int r = 30; r <= 60; r += 5) push(2, 0, t0 + r);
    push(1, 0, t0 + 65);
    key_n[0] = 1'b0;
    wait_cycles(35);
    chk("repeat_level_hi", key_level, 4'b0001);
    wait_cycles(20);
    key_n[0] = 1'b1;
    wait_cycles(30);
    chk("repeat_level_lo", key_level, 4'b0000);

    // Release bounce while held: no release, repeat cadence continues
    t0 = cyc + 1;
    push(0, 0, t0 + 10);
    for (int r = 30; r <= 55; r += 5) push(2, 0, t0 + r);
    push(1, 0, t0 + 58);
    key_n[0] = 1'b0;
    wait_cycles(32);
    key_n[0] = 1'b1;
    wait_cycles(4);
    key_n[0] = 1'b0;
    wait_cycles(2);
    chk("relbounce_level", key_level, 4'b0001);
    wait_cycles(10);
    key_n[0] = 1'b1;
    wait_cycles(30);
    chk("relbounce_level_lo", key_level, 4'b0000);

    // All four keys at once
    t0 = cyc + 1;
    for (int k = 0; k < int'(NK); k++) push(0, k, t0 + 10);
    for (int k = 0; k < int'(NK); k++) push(1, k, t0 + 25);
    key_n = 4'b0000;
    wait_cycles(15);
    chk("simul_level_hi", key_level, 4'b1111);
    key_n = 4'b1111;
    wait_cycles(25);
    chk("simul_level_lo", key_level, 4'b0000);

    // Reset mid-debounce on key 3, key held through reset release
    key_n[3] = 1'b0;
    wait_cycles(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_press", key_press, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      wait_cycles(1);
      chk("midrst_level",   key_level,   4'b0000);
      chk("midrst_release", key_release, 4'b0000);
      chk("midrst_repeat",  key_repeat,  4'b0000);
    end
    @(negedge clk);
    t1 = cyc + 1;
    push(0, 3, t1 + 10);
    push(1, 3, t1 + 30);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_cycles(19);
    chk("postrst_level", key_level, 4'b1000);
    key_n[3] = 1'b1;
    wait_cycles(25);
    chk("postrst_level_lo", key_level, 4'b0000);

    wait_cycles(5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending events, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
